// File: rtl/alu_issue_stage.sv
// alu_issue_stage: builds ALU operands and control from a micro-op, post-processes the ALU result, and holds it in a one-entry output slot.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready                   micro-op handshake
//   in_class, in_funct3, in_funct7b5    decoded op kind
//   in_rs1/rs2/imm/pc, in_rd            operands and destination
//   alu_a, alu_b, alu_ctr               combinational ALU drive
//   alu_out, alu_zero                   same-cycle ALU response
//   out_valid/out_ready                 result slot handshake
//   out_result, out_rd, out_wen, out_br_taken   registered outcome
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_class,
  input  logic [2:0]            in_funct3,
  input  logic                  in_funct7b5,
  input  logic [DATA_WIDTH-1:0] in_rs1,
  input  logic [DATA_WIDTH-1:0] in_rs2,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [4:0]            in_rd,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_ctr,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [4:0]            out_rd,
  output logic                  out_wen,
  output logic                  out_br_taken
);
  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b1000, AND = 4'b0111, OR = 4'b0110,
                         XOR = 4'b0100, SLL = 4'b0001, SRL = 4'b0101, SRA = 4'b1101;
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] res;
  logic lt_s, lt_u, tk, wen;
  always_comb begin
    alu_a = in_class inside {3'd4, 3'd5} ? in_pc : in_class == 3'd3 ? '0 : in_rs1;
    alu_b = in_class inside {3'd1, 3'd3, 3'd4} ? in_imm : in_class == 3'd5 ? DATA_WIDTH'(4) : in_rs2;
    alu_ctr = in_class == 3'd2 ? SUB :
              in_class > 3'd1 ? ADD :
              in_funct3 == 3'b000 ? ((in_class == 3'd0 && in_funct7b5) ? SUB : ADD) :
              in_funct3 == 3'b001 ? SLL :
              in_funct3[2:1] == 2'b01 ? SUB :
              in_funct3 == 3'b100 ? XOR :
              in_funct3 == 3'b101 ? (in_funct7b5 ? SRA : SRL) :
              in_funct3 == 3'b110 ? OR : AND;
    lt_s = $signed(alu_a) < $signed(alu_b);
    lt_u = alu_a < alu_b;
    // funct3[0] inverts blt/bltu into bge/bgeu; funct3[1] picks the unsigned compare
    tk = in_class == 3'd5 || (in_class == 3'd2 &&
         (in_funct3 == 3'b000 ? alu_zero :
          in_funct3 == 3'b001 ? !alu_zero :
          in_funct3[2] ? ((in_funct3[1] ? lt_u : lt_s) ^ in_funct3[0]) : 1'b0));
    res = in_class == 3'd2 ? in_pc + in_imm :
          in_class > 3'd5 ? '0 :
          (in_class < 3'd2 && in_funct3 == 3'b010) ? DATA_WIDTH'(lt_s) :
          (in_class < 3'd2 && in_funct3 == 3'b011) ? DATA_WIDTH'(lt_u) : alu_out;
    wen = in_rd != 5'd0 && in_class != 3'd2 && in_class < 3'd6;
  end
  assign out_valid = state == FULL;
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      out_result <= '0;
      out_rd <= '0;
      out_wen <= 1'b0;
      out_br_taken <= 1'b0;
    end else if (in_valid && in_ready) begin
      state <= FULL;
      out_result <= res;
      out_rd <= in_rd;
      out_wen <= wen;
      out_br_taken <= tk;
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed bench with a spec-level scoreboard for alu_issue_stage.
module tb_alu_issue_stage;
  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b1000, AND = 4'b0111, OR = 4'b0110,
                         XOR = 4'b0100, SLL = 4'b0001, SRL = 4'b0101, SRA = 4'b1101;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, in_ready, in_funct7b5 = 1'b0, alu_zero, out_valid, out_ready = 1'b1, out_wen, out_br_taken;
  logic [2:0] in_class = '0, in_funct3 = '0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0, in_imm = '0, in_pc = '0, alu_a, alu_b, alu_out, out_result;
  logic [4:0] in_rd = '0, out_rd;
  logic [3:0] alu_ctr;
  int checks = 0, failures = 0;

  alu_issue_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_out(alu_out), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wen(out_wen), .out_br_taken(out_br_taken)
  );

  always_comb begin
    case (alu_ctr)
      ADD: alu_out = alu_a + alu_b;
      SUB: alu_out = alu_a - alu_b;
      AND: alu_out = alu_a & alu_b;
      OR:  alu_out = alu_a | alu_b;
      XOR: alu_out = alu_a ^ alu_b;
      SLL: alu_out = alu_a << alu_b[4:0];
      SRL: alu_out = alu_a >> alu_b[4:0];
      SRA: alu_out = 32'($signed(alu_a) >>> alu_b[4:0]);
      default: alu_out = 32'hDEADBEEF;
    endcase
  end
  assign alu_zero = alu_out == 32'd0;

  typedef struct packed {
    logic [31:0] a, b, res;
    logic [3:0] ctr;
    logic wen, tk, ab_def;
  } exp_t;

  function automatic exp_t model(logic [2:0] cls, logic [2:0] f3, logic f7,
                                 logic [31:0] rs1, logic [31:0] rs2, logic [31:0] imm,
                                 logic [31:0] pc, logic [4:0] rd);
    exp_t e;
    logic [31:0] b;
    e = '0;
    e.ab_def = cls < 3'd6;
    b = cls == 3'd1 ? imm : rs2;
    case (cls)
      3'd0, 3'd1: begin
        e.a = rs1; e.b = b; e.wen = rd != 0;
        case (f3)
          3'd0: begin e.ctr = (cls == 0 && f7) ? SUB : ADD; e.res = (cls == 0 && f7) ? rs1 - b : rs1 + b; end
          3'd1: begin e.ctr = SLL; e.res = rs1 << b[4:0]; end
          3'd2: begin e.ctr = SUB; e.res = ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0; end
          3'd3: begin e.ctr = SUB; e.res = (rs1 < b) ? 32'd1 : 32'd0; end
          3'd4: begin e.ctr = XOR; e.res = rs1 ^ b; end
          3'd5: begin e.ctr = f7 ? SRA : SRL; e.res = f7 ? 32'($signed(rs1) >>> b[4:0]) : rs1 >> b[4:0]; end
          3'd6: begin e.ctr = OR; e.res = rs1 | b; end
          default: begin e.ctr = AND; e.res = rs1 & b; end
        endcase
      end
      3'd2: begin
        e.a = rs1; e.b = rs2; e.ctr = SUB; e.res = pc + imm;
        case (f3)
          3'd0: e.tk = rs1 == rs2;
          3'd1: e.tk = rs1 != rs2;
          3'd4: e.tk = $signed(rs1) < $signed(rs2);
          3'd5: e.tk = $signed(rs1) >= $signed(rs2);
          3'd6: e.tk = rs1 < rs2;
          3'd7: e.tk = rs1 >= rs2;
          default: e.tk = 1'b0;
        endcase
      end
      3'd3: begin e.a = 0; e.b = imm; e.res = imm; e.wen = rd != 0; end
      3'd4: begin e.a = pc; e.b = imm; e.res = pc + imm; e.wen = rd != 0; end
      3'd5: begin e.a = pc; e.b = 4; e.res = pc + 4; e.wen = rd != 0; e.tk = 1'b1; end
      default: e.ctr = ADD;
    endcase
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  exp_t slot = '0, cur;
  logic [4:0] slot_rd = '0;
  logic exp_valid = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid <= 1'b0;
      slot <= '0;
      slot_rd <= '0;
    end else if (in_valid && (!exp_valid || out_ready)) begin
      exp_valid <= 1'b1;
      slot <= model(in_class, in_funct3, in_funct7b5, in_rs1, in_rs2, in_imm, in_pc, in_rd);
      slot_rd <= in_rd;
    end else if (out_ready) begin
      exp_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    cur = model(in_class, in_funct3, in_funct7b5, in_rs1, in_rs2, in_imm, in_pc, in_rd);
    chk("alu_ctr", 32'(alu_ctr), 32'(cur.ctr));
    if (cur.ab_def) begin
      chk("alu_a", alu_a, cur.a);
      chk("alu_b", alu_b, cur.b);
    end
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("in_ready", 32'(in_ready), 32'(!exp_valid || out_ready));
    if (exp_valid || !rst_n) begin
      chk("out_result", out_result, slot.res);
      chk("out_rd", 32'(out_rd), 32'(slot_rd));
      chk("out_wen", 32'(out_wen), 32'(slot.wen));
      chk("out_br_taken", 32'(out_br_taken), 32'(slot.tk));
    end
  end

  task automatic op(logic [2:0] cls, logic [2:0] f3, logic f7, logic [31:0] rs1, logic [31:0] rs2,
                    logic [31:0] imm, logic [31:0] pc, logic [4:0] rd);
    in_valid = 1'b1; in_class = cls; in_funct3 = f3; in_funct7b5 = f7;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc; in_rd = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    op(3'd0, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3);
    #1 chk("sub_ctr", 32'(alu_ctr), 32'(4'b1000));
    step();
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_result", out_result, 32'hFFFFFFFE);
    chk("sub_wen", 32'(out_wen), 32'd1);
    op(3'd1, 3'd5, 1'b1, 32'h80000000, 32'd0, 32'd4, 32'd0, 5'd4);
    #1 chk("srai_ctr", 32'(alu_ctr), 32'(4'b1101));
    step();
    chk("srai_result", out_result, 32'hF8000000);
    op(3'd0, 3'd3, 1'b0, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd5);
    step();
    chk("sltu_result", out_result, 32'd1);
    op(3'd0, 3'd2, 1'b0, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd5);
    step();
    chk("slt_result", out_result, 32'd0);
    op(3'd2, 3'd0, 1'b0, 32'd9, 32'd9, 32'h20, 32'h100, 5'd1);
    step();
    chk("beq_taken", 32'(out_br_taken), 32'd1);
    chk("beq_target", out_result, 32'h120);
    chk("beq_wen", 32'(out_wen), 32'd0);
    op(3'd2, 3'd5, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 5'd1);
    step();
    chk("bge_taken", 32'(out_br_taken), 32'd0);
    op(3'd2, 3'd6, 1'b0, 32'd1, 32'hFFFFFFFF, 32'h8, 32'h40, 5'd0); step();
    op(3'd2, 3'd1, 1'b0, 32'd3, 32'd4, 32'h8, 32'h40, 5'd0); step();
    op(3'd2, 3'd3, 1'b0, 32'd3, 32'd4, 32'h8, 32'h40, 5'd0); step();
    op(3'd2, 3'd7, 1'b0, 32'd3, 32'd3, 32'h8, 32'h40, 5'd0); step();
    op(3'd1, 3'd0, 1'b1, 32'd10, 32'd0, 32'hFFFFFFFF, 32'd0, 5'd8); step();
    chk("addi_f7_result", out_result, 32'd9);
    op(3'd0, 3'd1, 1'b0, 32'h3, 32'h24, 32'd0, 32'd0, 5'd9); step();
    op(3'd0, 3'd5, 1'b0, 32'h80000000, 32'd4, 32'd0, 32'd0, 5'd9); step();
    op(3'd0, 3'd4, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd9); step();
    op(3'd1, 3'd6, 1'b0, 32'h10, 32'd0, 32'h1, 32'd0, 5'd9); step();
    op(3'd0, 3'd7, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd0); step();
    op(3'd3, 3'd0, 1'b0, 32'd7, 32'd7, 32'h12345000, 32'd0, 5'd2); step();
    chk("lui_result", out_result, 32'h12345000);
    op(3'd4, 3'd0, 1'b0, 32'd7, 32'd7, 32'h1000, 32'h400, 5'd2); step();
    chk("auipc_result", out_result, 32'h1400);
    op(3'd0, 3'd0, 1'b0, 32'd10, 32'd20, 32'd0, 32'd0, 5'd6); step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      op(3'd0, 3'd4, 1'b0, 32'(i), 32'(i * 3 + 1), 32'd0, 32'd0, 5'(i + 10));
      step();
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_result", out_result, 32'd30);
      chk("hold_rd", 32'(out_rd), 32'd6);
    end
    out_ready = 1'b1;
    op(3'd0, 3'd6, 1'b0, 32'hF0, 32'h0F, 32'd0, 32'd0, 5'd7);
    #1 chk("drain_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("replace_valid", 32'(out_valid), 32'd1);
    chk("replace_result", out_result, 32'hFF);
    op(3'd5, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFC, 5'd0); step();
    chk("jal_result", out_result, 32'd0);
    chk("jal_taken", 32'(out_br_taken), 32'd1);
    chk("jal_wen", 32'(out_wen), 32'd0);
    op(3'd7, 3'd0, 1'b0, 32'd5, 32'd6, 32'd7, 32'd8, 5'd9); step();
    chk("illegal_result", out_result, 32'd0);
    chk("illegal_wen", 32'(out_wen), 32'd0);
    op(3'd0, 3'd0, 1'b0, 32'd100, 32'd23, 32'd0, 32'd0, 5'd11); step();
    out_ready = 1'b0; in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_result", out_result, 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    op(3'd0, 3'd0, 1'b0, 32'd2, 32'd3, 32'd0, 32'd0, 5'd1);
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_result", out_result, 32'd5);
    in_valid = 1'b0;
    step(); step();
    chk("drained_valid", 32'(out_valid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-stage front end that sits on the operand/control side of the combinational ALU.
- Accepts one decoded micro-op per cycle over a valid/ready handshake and forms the ALU control code and operands.
- Drives the ALU combinationally, then post-processes ALU result and zero flag (SLT/SLTU, branch resolution, link address).
- Registers the outcome in a single output slot with backpressure toward writeback.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported (ALU shift amount is B[4:0]).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  micro-op valid
- in_ready  out  1  stage can accept a micro-op this cycle
- in_class  in  3  0=OP, 1=OP-IMM, 2=BRANCH, 3=LUI, 4=AUIPC, 5=JAL/JALR link, 6-7 illegal
- in_funct3  in  3  RISC-V funct3
- in_funct7b5  in  1  funct7[5] (imm[10] for OP-IMM shifts)
- in_rs1, in_rs2, in_imm, in_pc  in  DATA_WIDTH  operands, sign-extended immediate, instruction PC
- in_rd  in  5  destination register
- alu_a, alu_b  out  DATA_WIDTH  ALU operands (combinational from in_*)
- alu_ctr  out  4  ALU control code
- alu_out  in  DATA_WIDTH  ALU result (same cycle)
- alu_zero  in  1  ALU zero flag (same cycle)
- out_valid  out  1  result slot holds a result
- out_ready  in  1  writeback accepts the result
- out_result  out  DATA_WIDTH  writeback value, or branch target for BRANCH
- out_rd  out  5  destination register
- out_wen  out  1  register write enable
- out_br_taken  out  1  redirect required (taken branch, or JAL/JALR)

Behaviour:
- ALU codes: ADD=0000, SUB=1000, AND=0111, OR=0110, XOR=0100, SLL=0001, SRL=0101, SRA=1101. The stage must never emit any other code.
- Operand and code selection, combinational from in_*, independent of in_valid:
  - OP: A=rs1, B=rs2.
  - OP-IMM: A=rs1, B=imm.
  - funct3 mapping: 000 ADD, or SUB only when class OP and funct7b5=1; 001 SLL; 100 XOR; 101 SRA if funct7b5 else SRL; 110 OR; 111 AND.
  - funct3 010/011: code SUB, ALU result discarded; result is the local signed/unsigned compare of A<B, zero-extended 0/1.
  - BRANCH: A=rs1, B=rs2, code SUB.
    - taken: beq=alu_zero, bne=!alu_zero, blt/bge signed compare, bltu/bgeu unsigned compare.
    - funct3 010/011 are never taken.
    - result = in_pc+in_imm computed locally; wen=0.
  - LUI: A=0, B=imm, ADD.
  - AUIPC: A=pc, B=imm, ADD.
  - JAL/JALR: A=pc, B=4, ADD; br_taken=1. The target is computed upstream.
  - Illegal class (6-7): code ADD; captured result=0, wen=0, br_taken=0.
- out_wen = 1 for classes OP, OP-IMM, LUI, AUIPC, JAL/JALR when in_rd != 0; otherwise 0.
- Output slot: two-state FSM, EMPTY and FULL.
  - in_ready = !out_valid | out_ready (pass-through; a full slot that drains accepts a new op in the same cycle).
  - Accept on in_valid & in_ready: capture result, rd, wen, br_taken; out_valid=1 next edge. Latency is 1 cycle.
  - FULL & out_ready & !accept -> EMPTY.
  - FULL & !out_ready -> hold; all out_* stable, in_ready=0.
- Simultaneous drain and accept: the new op replaces the old, out_valid stays 1, no bubble.
- Held out_* must not change while out_valid=1 and out_ready=0, even if in_* toggle.
- Reset (asynchronous, any time, including while FULL): out_valid=0, out_result=0, out_rd=0, out_wen=0, out_br_taken=0. Any held result is dropped. in_ready=1 as soon as rst_n=0.
- Arithmetic: all sums wrap modulo 2^32. Signed compare uses bit 31.

Test Plan:
- OP funct3=000 funct7b5=1, rs1=5, rs2=7, rd=3 -> alu_ctr=1000; next cycle out_result=0xFFFFFFFE, wen=1, out_valid=1.
- OP-IMM funct3=101 funct7b5=1, rs1=0x80000000, imm=4 -> alu_ctr=1101, result 0xF8000000. OP funct3=011, rs1=1, rs2=0xFFFFFFFF -> result 1. Same operands with funct3=010 -> result 0.
- BRANCH funct3=000 (beq), rs1=rs2=9, pc=0x100, imm=0x20 -> br_taken=1, result 0x120, wen=0. Same op as bge with rs1=0xFFFFFFFF, rs2=1 -> br_taken=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid held -> in_ready=0, out_* frozen. Then out_ready=1 with new op -> in_ready=1, the next edge shows the new result, out_valid never drops.
- JAL pc=0xFFFFFFFC, rd=0 -> result 0x00000000 (wrap), br_taken=1, wen=0. Illegal class 7 -> result 0, wen=0.
- Assert rst_n low mid-cycle while FULL -> out_valid drops immediately, all outputs 0. Release -> first accepted op emerges after 1 cycle.
